pipe_stage_chain: RTL and testbench

Parametrised chain of pipeline latches with per-stage valid bits, back-pressure, bubble collapsing and synchronous flush. It generalises the fixed IF/ID and ID/EX latches into one reusable block. Stages between fetch, decode and execute instantiate it with the bundled control and data fields packed into `data`. Flush serves branch-taken squashing; stall serves load-use and downstream back-pressure.

---
 rtl/pipe_stage_chain.sv | 85 ++++++++
 tb/tb_pipe_stage_chain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Purpose  : Valid/ready pipeline latch chain with bubble collapsing and flush
// Revision : 1.0
// ============================================================================
module pipe_stage_chain #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] c_one = CW'(1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_vin;
    logic [WIDTH-1:0] w_din [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;

    // A stage moves when any slot from it to the output end is empty, or the
    // output drains; expressed flat to avoid a ripple through a self-referencing vector.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        assign w_adv[gi] = out_ready || !(&r_v[DEPTH-1:gi]);
        if (gi == 0) begin : g_head
            assign w_vin[gi] = in_valid;
            assign w_din[gi] = in_data;
        end else begin : g_body
            assign w_vin[gi] = r_v[gi-1];
            assign w_din[gi] = r_d[gi-1];
        end
    end

    assign in_ready   = w_adv[0] && !flush && !rst;
    assign out_valid  = r_v[DEPTH-1] && !flush && !rst;
    assign out_data   = r_d[DEPTH-1];
    assign count      = r_count;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            // Payload registers are deliberately left as they are.
            r_v     <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_v[i] <= w_vin[i];
                    if (w_vin[i]) begin
                        r_d[i] <= w_din[i];
                    end
                end
            end
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Purpose  : Directed self-checking bench for pipe_stage_chain (DEPTH 3 and 1)
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_chain;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [7:0]  b_in_data, b_out_data;
    logic [0:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .count(a_count)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [31:0] d);
        a_in_valid = v;
        a_in_data  = d;
    endtask

    logic [31:0] s_data [7];
    logic        s_vld  [7];
    logic [1:0]  e_cnt  [7];
    logic        e_ov   [7];
    logic [31:0] e_od   [7];

    initial begin
        int b_idx;
        int b_exp;
        int b_occ;
        logic b_ix, b_ox;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;

        // Reset
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", a_out_data, 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
        rst = 1'b0;

        // Streaming with out_ready held high
        s_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0};
        s_vld  = '{1, 1, 1, 1, 0, 0, 0};
        e_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        e_ov   = '{0, 0, 1, 1, 1, 1, 0};
        e_od   = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0};
        a_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            a_drive(s_vld[k], s_data[k]);
            #1;
            check("stream_in_ready", 32'(a_in_ready), 32'd1);
            tick();
            check("stream_count", 32'(a_count), 32'(e_cnt[k]));
            check("stream_out_valid", 32'(a_out_valid), 32'(e_ov[k]));
            if (e_ov[k]) check("stream_out_data", a_out_data, e_od[k]);
        end

        // Back-pressure: fill while the output is blocked
        a_out_ready = 1'b0;
        a_drive(1, 32'hA); tick();
        a_drive(1, 32'hB); tick();
        a_drive(1, 32'hC); tick();
        a_drive(1, 32'hD);
        #1;
        check("bp_count", 32'(a_count), 32'd3);
        check("bp_in_ready", 32'(a_in_ready), 32'd0);
        check("bp_out_data", a_out_data, 32'hA);
        tick();
        check("bp_hold_data", a_out_data, 32'hA);
        check("bp_hold_count", 32'(a_count), 32'd3);
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(a_in_ready), 32'd1);
        check("bp_release_out_valid", 32'(a_out_valid), 32'd1);
        tick();
        check("bp_release_count", 32'(a_count), 32'd3);
        check("bp_release_next", a_out_data, 32'hB);
        a_drive(0, 32'h0);
        tick(); check("bp_drain_c", a_out_data, 32'hC);
        tick(); check("bp_drain_d", a_out_data, 32'hD);
        check("bp_drain_count", 32'(a_count), 32'd1);
        tick(); check("bp_empty_valid", 32'(a_out_valid), 32'd0);
        check("bp_empty_count", 32'(a_count), 32'd0);

        // Bubble collapse
        a_out_ready = 1'b0;
        a_drive(1, 32'h1); tick();
        a_drive(0, 32'h0); tick();
        a_drive(1, 32'h2);
        #1;
        check("bub_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_drive(0, 32'h0);
        check("bub_count", 32'(a_count), 32'd2);
        tick();
        check("bub_count_hold", 32'(a_count), 32'd2);
        check("bub_out_data", a_out_data, 32'h1);
        a_out_ready = 1'b1;
        #1;
        check("bub_out_valid", 32'(a_out_valid), 32'd1);
        tick();
        check("bub_second_valid", 32'(a_out_valid), 32'd1);
        check("bub_second_data", a_out_data, 32'h2);
        tick();
        check("bub_empty", 32'(a_out_valid), 32'd0);

        // Flush with a full chain and a simultaneous offer
        a_out_ready = 1'b0;
        a_drive(1, 32'h5); tick();
        a_drive(1, 32'h6); tick();
        a_drive(1, 32'h7); tick();
        check("fl_pre_count", 32'(a_count), 32'd3);
        a_drive(1, 32'h99);
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        #1;
        check("fl_out_valid", 32'(a_out_valid), 32'd0);
        check("fl_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        a_flush = 1'b0;
        a_drive(0, 32'h0);
        #1;
        check("fl_count", 32'(a_count), 32'd0);
        check("fl_post_valid", 32'(a_out_valid), 32'd0);
        check("fl_post_in_ready", 32'(a_in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_no_ghost", 32'(a_out_valid), 32'd0);
        end

        // Reset mid-stream
        a_drive(1, 32'h51); tick();
        a_drive(1, 32'h52); tick();
        check("mr_pre_count", 32'(a_count), 32'd2);
        a_drive(0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_count", 32'(a_count), 32'd0);
        check("mr_out_valid", 32'(a_out_valid), 32'd0);
        check("mr_out_data", a_out_data, 32'd0);
        a_drive(1, 32'h77); tick();
        a_drive(0, 32'h0);  tick();
        check("mr_latency_early", 32'(a_out_valid), 32'd0);
        tick();
        check("mr_latency_valid", 32'(a_out_valid), 32'd1);
        check("mr_latency_data", a_out_data, 32'h77);

        // DEPTH=1: continuous input 0..9 with alternating out_ready
        b_idx = 0;
        b_exp = 0;
        b_occ = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            b_in_valid  = (b_idx < 10);
            b_in_data   = 8'(b_idx);
            b_out_ready = cyc[0];
            #1;
            b_ix = b_in_valid && b_in_ready;
            b_ox = b_out_valid && b_out_ready;
            if (b_ox) begin
                check("d1_out_data", 32'(b_out_data), 32'(b_exp));
                b_exp++;
            end
            if (b_ix) b_idx++;
            b_occ = b_occ + int'(b_ix) - int'(b_ox);
            tick();
            check("d1_count", 32'(b_count), 32'(b_occ));
        end
        b_in_valid = 1'b0;
        check("d1_delivered", 32'(b_exp), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
